// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the UART transmitter slice.
// Holds the default baud divisor (9600 baud from 50 MHz), the frame data
// width and the transmitter FSM state type.
package uart_pkg;

  localparam int CLK_PER_BIT_DEF = 5208;
  localparam int DATA_W          = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte queue feeding the UART transmitter; show-ahead read (rdata is the head).
// Latency: a pushed byte is visible at rdata/count on the next edge.
// Backpressure: push while full and pop while empty are ignored; a push on a
// full FIFO is dropped even if a pop happens on the same edge.
// Ports: clk, rst (sync, active-high), push/wdata, pop/rdata, full, empty, count.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [DATA_W-1:0]             wdata,
  input  logic                          pop,
  output logic [DATA_W-1:0]             rdata,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  // Full blocks the push outright, independent of a same-edge pop.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Depth is a power of two, so the pointers wrap naturally.
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter (LSB first) with an input byte FIFO.
// Latency: byte accepted at edge k -> popped at k+1 -> tx_uart falls at k+2.
// Backpressure: din_rdy = !full (registered occupancy, no path from din_vld).
// Ports: clk, rst (sync, active-high), din/din_vld/din_rdy byte input,
// tx_uart serial line (idles high), busy, fifo_cnt occupancy.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = CLK_PER_BIT_DEF,
  parameter int FIFO_DEPTH  = 4,
  parameter int STOP_BITS   = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_W-1:0]           din,
  input  logic                        din_vld,
  output logic                        din_rdy,
  output logic                        tx_uart,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_cnt
);

  localparam int BW = $clog2(CLK_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_PER_BIT - 1);
  localparam logic [2:0]    DATA_LAST = 3'(DATA_W - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  state_t            state;
  logic [BW-1:0]     baud_cnt;
  logic [2:0]        bit_cnt;
  logic [DATA_W-1:0] shift_reg;

  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_rdata;
  logic              push;
  logic              pop;
  logic              bit_end;
  logic              frame_end;

  assign din_rdy   = !fifo_full;
  assign push      = din_vld && din_rdy;
  assign bit_end   = (baud_cnt == BAUD_LAST);
  assign frame_end = (state == STOP) && bit_end && (bit_cnt == STOP_LAST);
  // Pop from IDLE, or at the last stop-bit cycle so the next start bit
  // follows with no idle gap.
  assign pop       = !fifo_empty && ((state == IDLE) || frame_end);
  assign busy      = (state != IDLE) || (fifo_cnt != '0);

  uart_tx_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (din),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  // tx_uart is registered from the current state, so the line trails the
  // FSM by one cycle; every bit still lasts exactly CLK_PER_BIT cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      tx_uart   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          tx_uart <= 1'b1;
          if (!fifo_empty) begin
            shift_reg <= fifo_rdata;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            state     <= START;
          end
        end

        START: begin
          tx_uart <= 1'b0;
          if (bit_end) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end

        DATA: begin
          tx_uart <= shift_reg[0];
          if (bit_end) begin
            baud_cnt  <= '0;
            shift_reg <= {1'b0, shift_reg[DATA_W-1:1]};
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              state   <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end

        STOP: begin
          tx_uart <= 1'b1;
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_cnt == STOP_LAST) begin
              bit_cnt <= '0;
              if (!fifo_empty) begin
                shift_reg <= fifo_rdata;
                state     <= START;
              end else begin
                state     <= IDLE;
              end
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end

        default: begin
          tx_uart <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: three instances (16 clk/bit 1 stop, 16 clk/bit
// 2 stop, default 5208 clk/bit). Inputs driven and outputs sampled on negedge.
module tb_uart_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [7:0] din_a = '0, din_b = '0, din_c = '0;
  logic       vld_a = 1'b0, vld_b = 1'b0, vld_c = 1'b0;
  logic       rdy_a, rdy_b, rdy_c;
  logic       tx_a, tx_b, tx_c;
  logic       busy_a, busy_b, busy_c;
  logic [2:0] cnt_a, cnt_b, cnt_c;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   rdy_low  = 0;
  logic mon_en   = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mon_en && !rdy_a) rdy_low <= rdy_low + 1;
  end

  uart_tx #(.CLK_PER_BIT(16), .FIFO_DEPTH(4), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst(rst), .din(din_a), .din_vld(vld_a), .din_rdy(rdy_a),
    .tx_uart(tx_a), .busy(busy_a), .fifo_cnt(cnt_a));

  uart_tx #(.CLK_PER_BIT(16), .FIFO_DEPTH(4), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst(rst), .din(din_b), .din_vld(vld_b), .din_rdy(rdy_b),
    .tx_uart(tx_b), .busy(busy_b), .fifo_cnt(cnt_b));

  uart_tx dut_c (
    .clk(clk), .rst(rst), .din(din_c), .din_vld(vld_c), .din_rdy(rdy_c),
    .tx_uart(tx_c), .busy(busy_c), .fifo_cnt(cnt_c));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic line(input int s);
    case (s)
      0:       return tx_a;
      1:       return tx_b;
      default: return tx_c;
    endcase
  endfunction

  // Returns with the current negedge sample being the first start-bit cycle.
  task automatic wait_fall(input int s, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (line(s) == 1'b0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Samples nbits bit windows of cpb cycles each, starting at the current
  // negedge; errs counts samples that disagree with the window's first one.
  task automatic capture(input int s, input int cpb, input int nbits,
                         output logic [11:0] lvl, output int errs);
    lvl  = '0;
    errs = 0;
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < cpb; c++) begin
        if (b != 0 || c != 0) @(negedge clk);
        if (c == 0) lvl[b] = line(s);
        else if (line(s) !== lvl[b]) errs++;
      end
    end
  endtask

  logic [7:0] t3_bytes [6] = '{8'h3C, 8'hC3, 8'h81, 8'h7E, 8'h12, 8'hED};
  logic [7:0] t2_bytes [3] = '{8'hA3, 8'h00, 8'hFF};

  initial begin
    bit          ok;
    logic [11:0] lvl;
    int          errs;

    // ---------------- reset ----------------
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_tx",   tx_a,   1);
    check_eq("rst_busy", busy_a, 0);
    check_eq("rst_rdy",  rdy_a,  1);
    check_eq("rst_cnt",  cnt_a,  0);
    check_eq("rst_tx_c", tx_c,   1);

    // ---------------- T1: single 0x55, latency ----------------
    din_a = 8'h55; vld_a = 1'b1;
    @(negedge clk);                        // after accept edge k
    vld_a = 1'b0;
    check_eq("t1_cnt_k",  cnt_a,  1);
    check_eq("t1_busy_k", busy_a, 1);
    check_eq("t1_tx_k",   tx_a,   1);
    @(negedge clk);                        // after pop edge k+1
    check_eq("t1_tx_k1",  tx_a,   1);
    check_eq("t1_cnt_k1", cnt_a,  0);
    check_eq("t1_busy_k1", busy_a, 1);
    @(negedge clk);                        // after edge k+2
    check_eq("t1_fall_k2", tx_a, 0);
    capture(0, 16, 10, lvl, errs);
    check_eq("t1_frame", lvl, 12'h2AA);
    check_eq("t1_bitlen", errs, 0);
    @(negedge clk);
    check_eq("t1_idle_tx",   tx_a,   1);
    check_eq("t1_idle_busy", busy_a, 0);

    // ---------------- T2: three back-to-back frames ----------------
    repeat (5) @(negedge clk);
    mon_en = 1'b1;
    vld_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din_a = t2_bytes[i];
      @(negedge clk);
    end
    vld_a = 1'b0;
    wait_fall(0, 20, ok);
    check_eq("t2_start", ok, 1);
    for (int f = 0; f < 3; f++) begin
      if (f != 0) begin
        @(negedge clk);
        check_eq("t2_nogap", tx_a, 0);
      end
      capture(0, 16, 10, lvl, errs);
      check_eq("t2_frame", lvl[9:0], {1'b1, t2_bytes[f], 1'b0});
      check_eq("t2_bitlen", errs, 0);
    end
    mon_en = 1'b0;
    check_eq("t2_rdy_high", rdy_low, 0);
    @(negedge clk);
    check_eq("t2_idle_busy", busy_a, 0);

    // ---------------- T3: hold din_vld, fill FIFO ----------------
    repeat (5) @(negedge clk);
    fork
      begin : driver
        int  idx;
        int  c0;
        logic r;
        idx = 0;
        c0 = cyc;
        din_a = t3_bytes[0];
        vld_a = 1'b1;
        for (int i = 0; i < 400 && idx < 6; i++) begin
          r = rdy_a;
          @(negedge clk);
          if (r) begin
            idx++;
            if (idx == 5) begin
              check_eq("t3_full_cnt", cnt_a, 4);
              check_eq("t3_full_rdy", rdy_a, 0);
            end
            if (idx == 6) check_eq("t3_6th_accept_cyc", cyc - c0, 163);
          end
          if (idx < 6) din_a = t3_bytes[idx];
          else vld_a = 1'b0;
        end
        vld_a = 1'b0;
        check_eq("t3_all_accepted", idx, 6);
      end
      begin : monitor
        bit          mok;
        logic [11:0] ml;
        int          me;
        wait_fall(0, 50, mok);
        check_eq("t3_start", mok, 1);
        for (int f = 0; f < 6; f++) begin
          if (f != 0) begin
            @(negedge clk);
            check_eq("t3_nogap", tx_a, 0);
          end
          capture(0, 16, 10, ml, me);
          check_eq("t3_frame", ml[9:0], {1'b1, t3_bytes[f], 1'b0});
          check_eq("t3_bitlen", me, 0);
        end
      end
    join

    // ---------------- T4: reset in the middle of DATA ----------------
    repeat (5) @(negedge clk);
    vld_a = 1'b1;
    din_a = 8'h00; @(negedge clk);
    din_a = 8'h11; @(negedge clk);
    din_a = 8'h22; @(negedge clk);
    vld_a = 1'b0;
    wait_fall(0, 20, ok);
    check_eq("t4_start", ok, 1);
    repeat (40) @(negedge clk);            // inside data bit 1 of 0x00
    check_eq("t4_pre_tx",  tx_a,  0);
    check_eq("t4_pre_cnt", cnt_a, 2);
    rst = 1'b1;
    @(negedge clk);
    check_eq("t4_rst_tx",   tx_a,   1);
    check_eq("t4_rst_cnt",  cnt_a,  0);
    check_eq("t4_rst_busy", busy_a, 0);
    check_eq("t4_rst_rdy",  rdy_a,  1);
    rst = 1'b0;
    wait_fall(0, 400, ok);
    check_eq("t4_no_restart", ok, 0);

    // ---------------- T5: two stop bits ----------------
    vld_b = 1'b1;
    din_b = 8'h0F; @(negedge clk);
    din_b = 8'h00; @(negedge clk);
    vld_b = 1'b0;
    wait_fall(1, 20, ok);
    check_eq("t5_start", ok, 1);
    capture(1, 16, 11, lvl, errs);
    check_eq("t5_frame", lvl, 12'h61E);
    check_eq("t5_bitlen", errs, 0);
    @(negedge clk);                        // 176 cycles after fall: next start
    check_eq("t5_len_11bits", tx_b, 0);
    capture(1, 16, 11, lvl, errs);
    check_eq("t5_frame2", lvl, 12'h600);
    @(negedge clk);
    check_eq("t5_idle_busy", busy_b, 0);

    // ---------------- T6: default timing, 0x5A ----------------
    din_c = 8'h5A; vld_c = 1'b1;
    @(negedge clk);
    vld_c = 1'b0;
    wait_fall(2, 20, ok);
    check_eq("t6_start", ok, 1);
    capture(2, 5208, 10, lvl, errs);
    check_eq("t6_byte",  lvl[8:1], 8'h5A);
    check_eq("t6_start_stop", {lvl[9], lvl[0]}, 2'b10);
    check_eq("t6_bitlen", errs, 0);
    @(negedge clk);
    check_eq("t6_idle_tx",   tx_c,   1);
    check_eq("t6_idle_busy", busy_c, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
